// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared opcode and status-flag types for arith_unit_pipe
package arith_pkg;

  typedef enum logic [1:0] {
    OP_DEC = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_NEG = 2'b11
  } arith_op_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } arith_flags_t;

endpackage

// File: rtl/ripple_adder.sv
// rtl/ripple_adder.sv - structural full-adder chain, WIDTH bits plus carry out
module ripple_adder #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]    = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1]  = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end

  assign cout = w_c[WIDTH];

endmodule

// File: rtl/arith_unit_pipe.sv
// rtl/arith_unit_pipe.sv - 2-stage valid/ready four-function adder with flags
// ARITH_SAT_EN: clamp g to MAX/MIN on signed overflow instead of wrapping.
module arith_unit_pipe
  import arith_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] g,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] r_a_in;
  logic [WIDTH-1:0] r_b_in;
  logic             r_cin;
  logic             r_s1_valid;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_g;
  arith_flags_t     r_flags;
  logic             r_ovf_sticky;

  arith_op_e        w_op;
  logic [WIDTH-1:0] w_a_sel;
  logic [WIDTH-1:0] w_b_sel;
  logic             w_cin_sel;
  logic             w_s2_en;
  logic             w_s1_en;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_v;
  logic [WIDTH-1:0] w_g;
  arith_flags_t     w_flags;

  assign w_op     = arith_op_e'(op);
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  // Every op is mapped onto a single adder: subtraction via ~b with cin=1.
  always_comb begin
    w_a_sel   = a;
    w_b_sel   = b;
    w_cin_sel = 1'b0;
    unique case (w_op)
      OP_DEC: w_b_sel = '1;
      OP_ADD: w_b_sel = b;
      OP_SUB: begin
        w_b_sel   = ~b;
        w_cin_sel = 1'b1;
      end
      OP_NEG: begin
        w_a_sel   = '0;
        w_b_sel   = ~b;
        w_cin_sel = 1'b1;
      end
      default: w_b_sel = b;
    endcase
  end

  ripple_adder #(.WIDTH(WIDTH)) u_adder (
    .x    (r_a_in),
    .y    (r_b_in),
    .cin  (r_cin),
    .sum  (w_sum),
    .cout (w_cout)
  );

  assign w_v = (r_a_in[MSB] == r_b_in[MSB]) && (w_sum[MSB] != r_a_in[MSB]);

  always_comb begin
    w_g = w_sum;
`ifdef ARITH_SAT_EN
    if (w_v) begin
      w_g = r_a_in[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    w_flags.z = (w_g == '0);
    w_flags.n = w_g[MSB];
    w_flags.c = w_cout;
    w_flags.v = w_v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_in       <= '0;
      r_b_in       <= '0;
      r_cin        <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_g          <= '0;
      r_flags      <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (w_s1_en) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_a_in <= w_a_sel;
          r_b_in <= w_b_sel;
          r_cin  <= w_cin_sel;
        end
      end
      if (w_s2_en) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_g     <= w_g;
          r_flags <= w_flags;
        end
      end
      // Clear wins over a same-cycle set from a consumed overflow.
      if (clr_sticky) begin
        r_ovf_sticky <= 1'b0;
      end else if (r_out_valid && out_ready && r_flags.v) begin
        r_ovf_sticky <= 1'b1;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign g          = r_g;
  assign flag_z     = r_flags.z;
  assign flag_n     = r_flags.n;
  assign flag_c     = r_flags.c;
  assign flag_v     = r_flags.v;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_arith_unit_pipe.sv
// tb/tb_arith_unit_pipe.sv - scoreboard bench for arith_unit_pipe (WIDTH=3 and WIDTH=8)
module tb_arith_unit_pipe;
  import arith_pkg::*;

  localparam int W = 3;
`ifdef ARITH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [1:0]   op;
  logic [W-1:0] a, b, g;
  logic         flag_z, flag_n, flag_c, flag_v, ovf_sticky, clr_sticky;

  logic         in_valid8, in_ready8, out_valid8, out_ready8;
  logic [1:0]   op8;
  logic [7:0]   a8, b8, g8;
  logic         z8, n8, c8, v8, sticky8;

  always #5 clk = ~clk;

  arith_unit_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .g(g),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  arith_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .op(op8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8), .g(g8),
    .flag_z(z8), .flag_n(n8), .flag_c(c8), .flag_v(v8),
    .ovf_sticky(sticky8), .clr_sticky(1'b0)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] gw, gs;
    logic         c, v;
  } vec_t;

  typedef struct {
    logic [W-1:0] g;
    logic         z, n, c, v;
    bit           lat;
    int           acc;
  } exp_t;

  vec_t tv[12];
  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic vec_t mkv(logic [1:0] o, logic [W-1:0] xa, logic [W-1:0] xb,
                               logic [W-1:0] gw, logic [W-1:0] gs, logic c, logic v);
    vec_t t;
    t.op = o; t.a = xa; t.b = xb; t.gw = gw; t.gs = gs; t.c = c; t.v = v;
    return t;
  endfunction

  // Drive one beat attempt at a falling edge; push expected if it will be accepted.
  task automatic try_beat(input int idx, input bit lat, input logic orr, output bit acc);
    exp_t e;
    vec_t t;
    t = tv[idx];
    @(negedge clk);
    out_ready = orr;
    in_valid  = 1'b1;
    op = t.op; a = t.a; b = t.b;
    #1;
    acc = in_ready;
    if (acc) begin
      e.g   = SAT ? t.gs : t.gw;
      e.z   = (e.g == '0);
      e.n   = e.g[W-1];
      e.c   = t.c;
      e.v   = t.v;
      e.lat = lat;
      e.acc = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic send(input int idx, input bit lat);
    bit acc;
    for (int t = 0; t < 50; t++) begin
      try_beat(idx, lat, 1'b1, acc);
      if (acc) return;
    end
    chk("send_timeout", 1, 0);
  endtask

  task automatic idle(input logic orr);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = orr;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && sbq.size() != 0; t++) begin
      @(negedge clk);
      #3;
    end
    chk("drain_empty", sbq.size(), 0);
    @(negedge clk);
    #3;
  endtask

  // Monitor: pops on every consumed result and checks output hold under backpressure.
  initial begin : monitor
    exp_t         e;
    bit           held_v = 1'b0;
    logic [W-1:0] held_g = '0;
    forever begin
      @(negedge clk);
      #2;
      if (held_v) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_g", g, held_g);
      end
      if (rst_n && out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("g", g, e.g);
          chk("flag_z", flag_z, e.z);
          chk("flag_n", flag_n, e.n);
          chk("flag_c", flag_c, e.c);
          chk("flag_v", flag_v, e.v);
          if (e.lat) chk("latency", cyc - e.acc, 2);
        end
      end
      held_v = rst_n && out_valid && !out_ready;
      held_g = g;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int k;
    bit acc;

    tv[0]  = mkv(OP_DEC, 3'b110, 3'b111, 3'b101, 3'b101, 1'b1, 1'b0);
    tv[1]  = mkv(OP_ADD, 3'b110, 3'b111, 3'b101, 3'b101, 1'b1, 1'b0);
    tv[2]  = mkv(OP_SUB, 3'b110, 3'b111, 3'b111, 3'b111, 1'b0, 1'b0);
    tv[3]  = mkv(OP_NEG, 3'b110, 3'b111, 3'b001, 3'b001, 1'b0, 1'b0);
    tv[4]  = mkv(OP_NEG, 3'b000, 3'b100, 3'b100, 3'b011, 1'b0, 1'b1);
    tv[5]  = mkv(OP_DEC, 3'b100, 3'b000, 3'b011, 3'b100, 1'b1, 1'b1);
    tv[6]  = mkv(OP_SUB, 3'b101, 3'b101, 3'b000, 3'b000, 1'b1, 1'b0);
    tv[7]  = mkv(OP_NEG, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    tv[8]  = mkv(OP_ADD, 3'b011, 3'b001, 3'b100, 3'b011, 1'b0, 1'b1);
    tv[9]  = mkv(OP_SUB, 3'b010, 3'b001, 3'b001, 3'b001, 1'b1, 1'b0);
    tv[10] = mkv(OP_DEC, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1, 1'b0);
    tv[11] = mkv(OP_DEC, 3'b000, 3'b000, 3'b111, 3'b111, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    op = '0; a = '0; b = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = '0; a8 = '0; b8 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_g", g, 0);
    chk("rst_flags", {flag_z, flag_n, flag_c, flag_v}, 0);
    chk("rst_sticky", ovf_sticky, 0);

    // Back-to-back stream of all four ops on the same operands.
    for (int i = 0; i < 4; i++) send(i, 1'b1);
    idle(1'b1);
    drain();
    chk("sticky_clean", ovf_sticky, 0);

    send(4, 1'b1);
    idle(1'b1);
    drain();
    chk("sticky_set", ovf_sticky, 1);

    send(5, 1'b1);
    send(6, 1'b1);
    send(7, 1'b1);
    idle(1'b1);
    drain();

    // Backpressure: only two beats fit while the output is stalled.
    k = 8;
    for (int c = 0; c < 4; c++) begin
      try_beat(k, 1'b0, 1'b0, acc);
      if (acc) k++;
    end
    chk("stall_accepts", k - 8, 2);
    chk("stall_in_ready", in_ready, 0);
    while (k < 12) begin
      send(k, 1'b0);
      k++;
    end
    idle(1'b1);
    drain();

    // Mid-stream reset drops in-flight beats and clears the sticky bit.
    for (int c = 0; c < 2; c++) try_beat(c, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sbq.delete();
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sticky", ovf_sticky, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    idle(1'b1);

    clr_sticky = 1'b1;
    send(4, 1'b1);
    idle(1'b1);
    drain();
    chk("clr_priority", ovf_sticky, 0);
    clr_sticky = 1'b0;
    @(negedge clk);
    #1;
    chk("clr_stays", ovf_sticky, 0);
    send(8, 1'b1);
    idle(1'b1);
    drain();
    chk("sticky_reset_then_set", ovf_sticky, 1);

    // WIDTH=8 signed overflow on 0x7F + 0x01.
    @(negedge clk);
    in_valid8 = 1'b1; op8 = OP_ADD; a8 = 8'h7F; b8 = 8'h01;
    @(negedge clk);
    in_valid8 = 1'b0;
    k = 0;
    while (!out_valid8 && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("w8_valid", out_valid8, 1);
    chk("w8_g", g8, SAT ? 8'h7F : 8'h80);
    chk("w8_v", v8, 1);

    chk("sb_final_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
